// File: rtl/serial_addsub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
// State encoding and counter sizing live here.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/serial_digit_adder.sv
// K-bit ripple-carry digit adder built from full-adder cells.
// Also exposes the carry into its top bit for overflow detection.
module serial_digit_adder #(
  parameter int K = 1
) (
  input  logic [K-1:0] a_i,
  input  logic [K-1:0] b_i,
  input  logic         c_i,
  output logic [K-1:0] s_o,
  output logic         c_o,
  output logic         c_top_o
);

  logic [K:0] c;

  assign c[0] = c_i;

  for (genvar i = 0; i < K; i++) begin : g_fa
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i])
                    | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign c_o     = c[K];
  assign c_top_o = c[K-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial N-bit adder/subtractor, K bits per clock, LSB first.
// Start/done handshake; results update only on completion or reset.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  if (N < 2 || K < 1 || K > N || (N % K) != 0) begin : g_bad
    $error("serial_addsub: illegal N/K combination");
  end

  localparam int D  = N / K;
  localparam int CW = clog2(D) + 1;
  localparam logic [CW-1:0] LAST = CW'(D - 1);

  state_e        state_q, state_d;
  logic [N-1:0]  a_q, b_q, r_q, sum_q;
  logic          c_q, cout_q, ovf_q;
  logic [CW-1:0] cnt_q;

  logic [K-1:0]  dsum;
  logic          dco, dtop;
  logic [N-1:0]  r_d;
  logic          last, accept;

  serial_digit_adder #(.K(K)) u_dig (
    .a_i    (a_q[K-1:0]),
    .b_i    (b_q[K-1:0]),
    .c_i    (c_q),
    .s_o    (dsum),
    .c_o    (dco),
    .c_top_o(dtop)
  );

  // New digit enters from the MSB side of the partial result
  assign r_d    = N'({dsum, r_q} >> K);
  assign last   = (cnt_q == LAST);
  assign accept = start
                & ((state_q == IDLE) | (state_q == DONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    unique case (state_q)
      IDLE:    state_d = start ? RUN : IDLE;
      RUN:     state_d = last ? DONE : RUN;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      r_q    <= '0;
      c_q    <= 1'b0;
      cnt_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= sub ? ~b : b;
      c_q   <= sub;
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      a_q   <= a_q >> K;
      b_q   <= b_q >> K;
      r_q   <= r_d;
      c_q   <= dco;
      cnt_q <= cnt_q + CW'(1);
      if (last) begin
        sum_q  <= r_d;
        cout_q <= dco;
        ovf_q  <= dtop ^ dco;
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Randomised and directed bench for serial_addsub over five N/K
// configurations, checked against an integer arithmetic model.
module tb_serial_addsub;

  localparam int NC = 5;
  localparam int NS[NC] = '{8, 8, 8, 8, 16};
  localparam int KS[NC] = '{1, 2, 4, 8, 4};

  logic        clk, rst;
  logic        start_s[NC], sub_s[NC];
  logic [15:0] a_s[NC], b_s[NC], sum_w[NC];
  logic        busy_w[NC], done_w[NC];
  logic        cout_w[NC], ovf_w[NC];

  int n_cmp = 0;
  int n_err = 0;

  for (genvar g = 0; g < NC; g++) begin : g_dut
    localparam int NN = NS[g];
    localparam int KK = KS[g];
    logic [NN-1:0] s;
    serial_addsub #(.N(NN), .K(KK)) u_dut (
      .clk  (clk),
      .rst  (rst),
      .start(start_s[g]),
      .sub  (sub_s[g]),
      .a    (a_s[g][NN-1:0]),
      .b    (b_s[g][NN-1:0]),
      .busy (busy_w[g]),
      .done (done_w[g]),
      .sum  (s),
      .cout (cout_w[g]),
      .ovf  (ovf_w[g])
    );
    assign sum_w[g] = 16'(s);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Plain signed/unsigned arithmetic reference
  task automatic model(input int n,
                       input logic [15:0] av, bv,
                       input logic sb,
                       output logic [15:0] s,
                       output logic co, ov);
    int mask, ai, bi, sa, sbv, r, rs;
    mask = (1 << n) - 1;
    ai   = int'(av) & mask;
    bi   = int'(bv) & mask;
    sa   = (ai >= (1 << (n-1))) ? ai - (1 << n) : ai;
    sbv  = (bi >= (1 << (n-1))) ? bi - (1 << n) : bi;
    if (!sb) begin
      r  = ai + bi;
      co = (r >= (1 << n));
      rs = sa + sbv;
    end else begin
      r  = ai - bi;
      co = (ai >= bi);
      rs = sa - sbv;
    end
    s  = 16'(r & mask);
    ov = (rs > (1 << (n-1)) - 1) || (rs < -(1 << (n-1)));
  endtask

  task automatic op(input int g,
                    input logic [15:0] av, bv,
                    input logic sb);
    int lat, bad;
    logic [15:0] es;
    logic ec, eo;
    @(negedge clk);
    start_s[g] = 1'b1;
    a_s[g]     = av;
    b_s[g]     = bv;
    sub_s[g]   = sb;
    @(posedge clk);
    #1;
    start_s[g] = 1'b0;
    a_s[g]     = 16'($urandom);
    b_s[g]     = 16'($urandom);
    sub_s[g]   = 1'($urandom);
    lat = 0;
    bad = 0;
    while (!done_w[g] && lat < 64) begin
      if (!busy_w[g]) bad++;
      @(posedge clk);
      #1;
      lat++;
    end
    model(NS[g], av, bv, sb, es, ec, eo);
    chk("latency", lat, NS[g] / KS[g]);
    chk("busy_run", bad, 0);
    chk("busy_done", busy_w[g], 1'b0);
    chk("sum", sum_w[g], es);
    chk("cout", cout_w[g], ec);
    chk("ovf", ovf_w[g], eo);
  endtask

  initial begin
    int nd, d, cyc;
    logic [15:0] held;
    rst = 1'b1;
    for (int g = 0; g < NC; g++) begin
      start_s[g] = 1'b0;
      sub_s[g]   = 1'b0;
      a_s[g]     = '0;
      b_s[g]     = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < NC; g++) begin
      chk("rst_busy", busy_w[g], 1'b0);
      chk("rst_done", done_w[g], 1'b0);
      chk("rst_sum", sum_w[g], 16'h0);
      chk("rst_cout", cout_w[g], 1'b0);
      chk("rst_ovf", ovf_w[g], 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;

    op(0, 16'h0F, 16'h01, 1'b0);
    chk("tp_0f", sum_w[0], 16'h10);
    op(0, 16'h7F, 16'h01, 1'b0);
    chk("tp_7f_ovf", ovf_w[0], 1'b1);
    op(0, 16'h80, 16'h01, 1'b1);
    chk("tp_80_sum", sum_w[0], 16'h7F);
    op(2, 16'hFF, 16'h01, 1'b0);
    chk("tp_k4_cout", cout_w[2], 1'b1);
    op(3, 16'hFF, 16'h01, 1'b0);
    chk("tp_k8_sum", sum_w[3], 16'h00);
    op(0, 16'h00, 16'h01, 1'b1);
    chk("tp_borrow", sum_w[0], 16'hFF);

    // start held high on the K=2 unit; a tags each edge
    d = NS[1] / KS[1];
    held = sum_w[1];
    for (cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk);
      start_s[1] = 1'b1;
      sub_s[1]   = 1'b0;
      a_s[1]     = 16'(cyc);
      b_s[1]     = 16'h10;
      @(posedge clk);
      #1;
      chk("b2b_done", done_w[1], (cyc % (d + 1)) == 0);
      chk("b2b_busy", busy_w[1], (cyc % (d + 1)) != 0);
      if (done_w[1]) begin
        chk("b2b_sum", sum_w[1], 16'((cyc - d) + 16'h10));
        held = sum_w[1];
      end else begin
        chk("b2b_hold", sum_w[1], held);
      end
    end
    @(negedge clk);
    start_s[1] = 1'b0;
    repeat (d + 2) @(posedge clk);

    // abort mid-operation with an asynchronous reset
    @(negedge clk);
    start_s[0] = 1'b1;
    a_s[0]     = 16'hAA;
    b_s[0]     = 16'h55;
    sub_s[0]   = 1'b0;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", busy_w[0], 1'b0);
    chk("abort_done", done_w[0], 1'b0);
    chk("abort_sum", sum_w[0], 16'h0);
    chk("abort_cout", cout_w[0], 1'b0);
    chk("abort_ovf", ovf_w[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done_w[0]) nd++;
    end
    chk("abort_nodone", nd, 0);
    op(0, 16'h12, 16'h34, 1'b0);
    chk("abort_next", sum_w[0], 16'h46);

    for (int g = 0; g < NC; g++) begin
      for (int i = 0; i < 1000; i++) begin
        op(g, 16'($urandom), 16'($urandom),
           1'($urandom_range(0, 1)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
